array5_unpacker: RTL and testbench
==================================

ARRAY5_UNPACKER -- requirements
Module: array5_unpacker

Interface
REQ-001 The block SHALL have these ports: clk  input  1  clock, rising edge.
REQ-002 The block SHALL have these ports: rst  input  1  reset, asynchronous, active-high.
REQ-003 arr_in  input  int_5  five-element signed 32-bit array offered by the upstream producer.
REQ-004 arr_in_sync  input  1  upstream holds a valid array on arr_in.
REQ-005 arr_in_notify  output  1  block ready to take an array.
REQ-006 elem_out  output  integer  current array element.
REQ-007 elem_idx  output  3  index 0..4 of elem_out within its array.
REQ-008 elem_last  output  1  high when elem_idx == 4.
REQ-009 elem_out_sync  input  1  downstream ready to take an element.
REQ-010 elem_out_notify  output  1  elem_out/elem_idx/elem_last valid.
REQ-011 arr_count  output  32  number of arrays fully unpacked, unsigned, wraps 2^32-1 -> 0.

Function
REQ-012 A transfer on either port SHALL occur only in a cycle where that port's sync and notify are both high at the rising clk edge.
REQ-013 The block SHALL be a two-state FSM: IDLE (arr_in_notify=1, elem_out_notify=0) and SEND (arr_in_notify=0, elem_out_notify=1).
REQ-014 IDLE with an arr_in transfer SHALL, at that edge:
- latch all five elements into an internal int_5 buffer;
- drive elem_out=buf[0], elem_idx=0, elem_last=0;
- go to SEND.
REQ-015 IDLE without an arr_in transfer SHALL hold all outputs unchanged.
REQ-016 SEND with an elem_out transfer and elem_idx<4 SHALL advance to elem_idx+1, drive the matching buffer element, and stay in SEND.
REQ-017 SEND with an elem_out transfer and elem_idx==4 SHALL:
- increment arr_count modulo 2^32;
- go to IDLE.
REQ-018 SEND without an elem_out transfer SHALL hold elem_out, elem_idx and elem_last stable, so downstream may stall indefinitely.
REQ-019 arr_in SHALL be sampled only at the accepting edge; later changes on arr_in SHALL NOT affect elements in flight.
REQ-020 arr_in_sync in SEND SHALL be ignored; no array is accepted until the state returns to IDLE.
REQ-021 Latency SHALL be one cycle from the arr_in accept edge to elem_out_notify=1; minimum period is 6 cycles per array.
REQ-022 elem_out SHALL carry buffer elements bit-exact, including negative values and 32'h8000_0000.
REQ-023 All outputs SHALL be registered; there SHALL be no combinational path from sync inputs to notify outputs.

Reset
REQ-024 While rst is high, outputs SHALL be: state=IDLE, arr_in_notify=1, elem_out_notify=0, elem_out=0, elem_idx=0, elem_last=0, arr_count=0, buffer all 0.
REQ-025 Reset asserted mid-SEND SHALL abandon the partial array immediately; arr_count SHALL NOT be incremented for it.
REQ-026 On the first edge after rst deasserts, an arr_in transfer SHALL be accepted.

Structure
REQ-027 int_5 SHALL come from scam_model_types.
REQ-028 The FSM state enum (IDLE, SEND) SHALL live in a package array5_unpacker_types.
REQ-029 The block SHALL be a single module with no sub-modules; the index counter and buffer SHALL be inline.

Verification
REQ-030 Basic: arr_in={1,2,3,4,5} accepted with elem_out_sync held at 1 -> elements 1,2,3,4,5 on consecutive cycles with idx 0..4, elem_last only on 5, then arr_count=1, arr_in_notify=1.
REQ-031 Backpressure: elem_out_sync held low 10 cycles after the first element -> elem_out stays at {value 1, idx 0}; the sequence resumes unchanged when sync rises.
REQ-032 Input isolation: change arr_in to {9,9,9,9,9} and pulse arr_in_sync during SEND -> output remains 1..5 and no second accept occurs.
REQ-033 Signed values: arr_in={-1, 32'h8000_0000, 0, 32'h7FFF_FFFF, -5} -> bit-exact output.
REQ-034 Reset mid-operation: assert rst after elements 1 and 2 are taken -> all reset values, arr_count=0; the next array {6,7,8,9,10} unpacks correctly.
REQ-035 Wrap and back-to-back: preload arr_count to 32'hFFFF_FFFF by forcing, or run 2 arrays with arr_in_sync held at 1 -> accept edges 6 cycles apart, arr_count ends at 0 (forced case) or 2.

Source files
------------

// File: rtl/array5_unpacker_types.sv
// State encoding and constants for the five-element array unpacker.
package array5_unpacker_types;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX = 3'd4;

endpackage

// File: rtl/scam_model_types.sv
// Shared model types for the array-oriented datapath blocks.
package scam_model_types;

    typedef logic signed [31:0] int_5 [5];

endpackage

// File: rtl/array5_unpacker.sv
// Accepts a five-element signed array in one handshake and streams the elements
// out one per handshake, counting completed arrays.
module array5_unpacker
    import scam_model_types::*;
    import array5_unpacker_types::*;
(
    input  logic               clk,
    input  logic               rst,
    input  int_5               arr_in,
    input  logic               arr_in_sync,
    output logic               arr_in_notify,
    output logic signed [31:0] elem_out,
    output logic [2:0]         elem_idx,
    output logic               elem_last,
    input  logic               elem_out_sync,
    output logic               elem_out_notify,
    output logic [31:0]        arr_count
);

    state_t     state_reg;
    int_5       buf_reg;
    logic [2:0] next_idx;

    assign next_idx = elem_idx + 3'd1;

    // Notify flags are registered alongside the state so that no sync input
    // reaches a notify output combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= IDLE;
            arr_in_notify   <= 1'b1;
            elem_out_notify <= 1'b0;
            elem_out        <= '0;
            elem_idx        <= '0;
            elem_last       <= 1'b0;
            arr_count       <= '0;
            for (int i = 0; i < 5; i++) begin
                buf_reg[i] <= '0;
            end
        end else begin
            case (state_reg)
                IDLE: begin
                    if (arr_in_sync && arr_in_notify) begin
                        for (int i = 0; i < 5; i++) begin
                            buf_reg[i] <= arr_in[i];
                        end
                        elem_out        <= arr_in[0];
                        elem_idx        <= '0;
                        elem_last       <= 1'b0;
                        arr_in_notify   <= 1'b0;
                        elem_out_notify <= 1'b1;
                        state_reg       <= SEND;
                    end
                end
                SEND: begin
                    if (elem_out_sync && elem_out_notify) begin
                        if (elem_idx == LAST_IDX) begin
                            // Element outputs keep the last value while idle.
                            arr_count       <= arr_count + 32'd1;
                            arr_in_notify   <= 1'b1;
                            elem_out_notify <= 1'b0;
                            state_reg       <= IDLE;
                        end else begin
                            elem_idx  <= next_idx;
                            elem_out  <= buf_reg[next_idx];
                            elem_last <= (next_idx == LAST_IDX);
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_array5_unpacker.sv
// Table-driven and scoreboard-checked bench for array5_unpacker.
module tb_array5_unpacker;
    import scam_model_types::*;

    typedef struct packed {
        logic [31:0] val;
        logic [2:0]  idx;
        logic        last;
    } exp_t;

    typedef struct {
        int_5        arr;
        logic [31:0] cnt;
    } vec_t;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    int_5               arr_in;
    logic               arr_in_sync = 1'b0;
    logic               arr_in_notify;
    logic signed [31:0] elem_out;
    logic [2:0]         elem_idx;
    logic               elem_last;
    logic               elem_out_sync = 1'b0;
    logic               elem_out_notify;
    logic [31:0]        arr_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc_no = 0;
    exp_t        exp_q[$];
    int          accept_cyc[$];
    logic [31:0] exp_count = 0;
    vec_t        tbl[4];

    array5_unpacker dut (
        .clk            (clk),
        .rst            (rst),
        .arr_in         (arr_in),
        .arr_in_sync    (arr_in_sync),
        .arr_in_notify  (arr_in_notify),
        .elem_out       (elem_out),
        .elem_idx       (elem_idx),
        .elem_last      (elem_last),
        .elem_out_sync  (elem_out_sync),
        .elem_out_notify(elem_out_notify),
        .arr_count      (arr_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_no++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int_5 a);
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            e.val  = a[k];
            e.idx  = 3'(k);
            e.last = (k == 4);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: handshakes are evaluated on the falling edge, half a cycle
    // before the rising edge that completes them.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            exp_q.delete();
        end else begin
            if (arr_in_notify && arr_in_sync) begin
                accept_cyc.push_back(cyc_no);
                $display("accept cycle=%0d", cyc_no);
            end
            if (elem_out_notify && elem_out_sync) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_elem", {elem_out, elem_idx, elem_last}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    check("elem", {elem_out, elem_idx, elem_last}, 64'(e));
                    $display("elem cycle=%0d idx=%0d val=%0h last=%0b",
                             cyc_no, elem_idx, elem_out, elem_last);
                end
            end
        end
    end

    task automatic send(input int_5 a);
        int n = 0;
        while (!arr_in_notify && n < 20) begin
            cyc();
            n++;
        end
        check("ready_before_send", arr_in_notify, 1);
        arr_in      = a;
        arr_in_sync = 1'b1;
        push(a);
        cyc();
        arr_in_sync = 1'b0;
        check("latency_elem_notify", elem_out_notify, 1);
        check("busy_in_send", arr_in_notify, 0);
    endtask

    task automatic drain(input int arrays);
        int n = 0;
        elem_out_sync = 1'b1;
        while (exp_q.size() > 0 && n < 60) begin
            cyc();
            n++;
        end
        check("drained", exp_q.size(), 0);
        elem_out_sync = 1'b0;
        exp_q.delete();
        exp_count = exp_count + 32'(arrays);
        check("idle_in_notify", arr_in_notify, 1);
        check("idle_out_notify", elem_out_notify, 0);
        check("arr_count", arr_count, exp_count);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_notify"}, arr_in_notify, 1);
        check({tag, "_out_notify"}, elem_out_notify, 0);
        check({tag, "_elem"}, {elem_out, elem_idx, elem_last}, 0);
        check({tag, "_count"}, arr_count, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   na;
        int_5 a;
        for (int k = 0; k < 5; k++) arr_in[k] = '0;

        tbl[0].arr = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        tbl[0].cnt = 32'd1;
        tbl[1].arr = '{-32'sd1, 32'sh8000_0000, 32'sd0, 32'sh7FFF_FFFF, -32'sd5};
        tbl[1].cnt = 32'd2;
        tbl[2].arr = '{32'sd100, -32'sd200, 32'sd300, -32'sd400, 32'sd500};
        tbl[2].cnt = 32'd3;
        tbl[3].arr = '{32'shDEAD_BEEF, 32'sh0123_4567, 32'shFFFF_FFFE, 32'sh0000_0001, 32'shA5A5_5A5A};
        tbl[3].cnt = 32'd4;

        #1 rst = 1'b1;
        #20;
        check_reset_state("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send(tbl[i].arr);
            drain(1);
            check("table_count", arr_count, tbl[i].cnt);
        end

        // Backpressure: downstream stalls for ten cycles on the first element.
        a = '{32'sd1, 32'sd2, 32'sd3, 32'sd4, 32'sd5};
        send(a);
        for (int k = 0; k < 10; k++) begin
            cyc();
            check("stall_hold", {elem_out, elem_idx, elem_last, elem_out_notify},
                  {32'd1, 3'd0, 1'b0, 1'b1});
        end
        drain(1);

        // Input isolation: new data and sync pulse while busy are ignored.
        send(a);
        na = accept_cyc.size();
        for (int k = 0; k < 5; k++) arr_in[k] = 32'sd9;
        arr_in_sync = 1'b1;
        cyc();
        cyc();
        arr_in_sync = 1'b0;
        drain(1);
        check("no_second_accept", accept_cyc.size(), na);
        repeat (3) cyc();
        check("stays_idle", elem_out_notify, 0);

        // Reset after two elements have been taken.
        send(a);
        elem_out_sync = 1'b1;
        cyc();
        cyc();
        elem_out_sync = 1'b0;
        rst = 1'b1;
        #2;
        check_reset_state("mid_reset");
        exp_count = 0;
        cyc();
        rst = 1'b0;
        a = '{32'sd6, 32'sd7, 32'sd8, 32'sd9, 32'sd10};
        send(a);
        drain(1);

        // Back-to-back: sync held high accepts a new array every six cycles.
        a = '{32'sd11, 32'sd12, 32'sd13, 32'sd14, 32'sd15};
        arr_in = a;
        push(a);
        push(a);
        na = accept_cyc.size();
        arr_in_sync   = 1'b1;
        elem_out_sync = 1'b1;
        for (int n = 0; n < 30 && accept_cyc.size() < na + 2; n++) cyc();
        arr_in_sync = 1'b0;
        check("b2b_accepts", accept_cyc.size(), na + 2);
        if (accept_cyc.size() >= na + 2)
            check("b2b_spacing", accept_cyc[na+1] - accept_cyc[na], 6);
        drain(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
